// File: rtl/fmap_buf_pkg.sv
// Shared constants and helpers for the feature-map ping-pong buffer controller.
package fmap_buf_pkg;

  localparam int MAX_BANK   = 4;
  localparam int BANK_IDX_W = 2;
  localparam int BANK_CNT_W = 3;

  // Advance a bank pointer, wrapping modulo n_bank (n_bank need not be a power of two).
  function automatic logic [BANK_IDX_W-1:0] next_idx(input logic [BANK_IDX_W-1:0] idx,
                                                     input int n_bank);
    if (int'(idx) >= n_bank - 1) return '0;
    else return idx + BANK_IDX_W'(1);
  endfunction

endpackage

// File: rtl/fmap_pingpong_ctrl_rd_lat_pipe.sv
// RD_LAT-deep shift register carrying {valid, bank index} alongside BRAM read latency.
module rd_lat_pipe #(
  parameter int STAGES = 1,
  parameter int IDX_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx
);

  logic [STAGES-1:0] vld_p;
  logic [IDX_W-1:0]  idx_p [STAGES];

  // Valid chain: cleared on reset so in-flight reads never return after a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_vld;
      for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Index chain: data only, qualified by the valid chain, so no reset needed.
  always_ff @(posedge clk) begin
    idx_p[0] <= in_idx;
    for (int i = 1; i < STAGES; i++) idx_p[i] <= idx_p[i-1];
  end

  assign out_vld = vld_p[STAGES-1];
  assign out_idx = idx_p[STAGES-1];

endmodule

// File: rtl/fmap_pingpong_ctrl.sv
// N-bank ping-pong controller between a producer layer (writes tiles) and a
// consumer layer (reads tiles). Bank ownership is two pointers plus a fill count.
module fmap_pingpong_ctrl
  import fmap_buf_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12,
  parameter int N_BANK = 2,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_last,
  output logic                     rd_bank_valid,
  input  logic                     rd_req,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_done,
  output logic                     rd_dvalid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [N_BANK-1:0]        bram_we,
  output logic [N_BANK*ADDR_W-1:0] bram_waddr,
  output logic [N_BANK*DATA_W-1:0] bram_din,
  output logic [ADDR_W-1:0]        bram_raddr,
  input  logic [N_BANK*DATA_W-1:0] bram_dout,
  output logic [BANK_CNT_W-1:0]    full_cnt,
  output logic [BANK_IDX_W-1:0]    wbank,
  output logic [BANK_IDX_W-1:0]    rbank,
  output logic                     err_underflow
);

  logic                  wr_acc;
  logic                  commit;
  logic                  rd_acc;
  logic                  rel;
  logic [BANK_IDX_W-1:0] rd_idx_p;

  assign wr_ready      = (full_cnt < BANK_CNT_W'(N_BANK));
  assign rd_bank_valid = (full_cnt != '0);

  assign wr_acc = wr_valid & wr_ready;
  assign commit = wr_acc & wr_last;
  assign rd_acc = rd_req & rd_bank_valid;
  assign rel    = rd_done & rd_bank_valid;

  // Address and data fan out to every bank; only the write enable selects the bank.
  assign bram_waddr = {N_BANK{wr_addr}};
  assign bram_din   = {N_BANK{wr_data}};
  assign bram_raddr = rd_addr;

  // One-hot write enable on the current write bank.
  always_comb begin
    bram_we = '0;
    for (int b = 0; b < N_BANK; b++) bram_we[b] = wr_acc && (wbank == BANK_IDX_W'(b));
  end

  // Bank pointers, fill count and sticky underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_cnt      <= '0;
      wbank         <= '0;
      rbank         <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (commit) wbank <= next_idx(wbank, N_BANK);
      if (rel)    rbank <= next_idx(rbank, N_BANK);
      case ({commit, rel})
        2'b10:   full_cnt <= full_cnt + BANK_CNT_W'(1);
        2'b01:   full_cnt <= full_cnt - BANK_CNT_W'(1);
        default: full_cnt <= full_cnt;
      endcase
      if ((rd_req || rd_done) && !rd_bank_valid) err_underflow <= 1'b1;
    end
  end

  // Read index travels with the request so an early release cannot redirect returning data.
  rd_lat_pipe #(
    .STAGES (RD_LAT),
    .IDX_W  (BANK_IDX_W)
  ) u_rd_lat_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (rd_acc),
    .in_idx  (rbank),
    .out_vld (rd_dvalid),
    .out_idx (rd_idx_p)
  );

  // Return-data mux selected by the delayed bank index.
  always_comb begin
    rd_data = '0;
    for (int b = 0; b < N_BANK; b++) begin
      if (rd_idx_p == BANK_IDX_W'(b)) rd_data = bram_dout[b*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_fmap_pingpong_ctrl.sv
// Directed bench: three controller instances (2 banks/lat 1, 2 banks/lat 2,
// 3 banks/lat 1) share one stimulus stream, each with its own BRAM model.
module tb_fmap_pingpong_ctrl;

  localparam int DW = 64;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          wr_valid, wr_last, rd_req, rd_done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;

  logic            wr_ready_a, rbv_a, dv_a, err_a;
  logic [DW-1:0]   rdata_a;
  logic [1:0]      we_a;
  logic [2*AW-1:0] waddr_a;
  logic [2*DW-1:0] din_a, dout_a;
  logic [AW-1:0]   raddr_a;
  logic [2:0]      fc_a;
  logic [1:0]      wb_a, rb_a;

  logic            wr_ready_b, rbv_b, dv_b, err_b;
  logic [DW-1:0]   rdata_b;
  logic [1:0]      we_b;
  logic [2*AW-1:0] waddr_b;
  logic [2*DW-1:0] din_b, s1_b, dout_b;
  logic [AW-1:0]   raddr_b;
  logic [2:0]      fc_b;
  logic [1:0]      wb_b, rb_b;

  logic            wr_ready_c, rbv_c, dv_c, err_c;
  logic [DW-1:0]   rdata_c;
  logic [2:0]      we_c;
  logic [3*AW-1:0] waddr_c;
  logic [3*DW-1:0] din_c, dout_c;
  logic [AW-1:0]   raddr_c;
  logic [2:0]      fc_c;
  logic [1:0]      wb_c, rb_c;

  logic [DW-1:0] mem_a [2][16];
  logic [DW-1:0] mem_b [2][16];
  logic [DW-1:0] mem_c [3][16];

  int checks   = 0;
  int failures = 0;

  fmap_pingpong_ctrl #(.DATA_W(DW), .ADDR_W(AW), .N_BANK(2), .RD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_a),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .rd_bank_valid(rbv_a), .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done),
    .rd_dvalid(dv_a), .rd_data(rdata_a), .bram_we(we_a), .bram_waddr(waddr_a),
    .bram_din(din_a), .bram_raddr(raddr_a), .bram_dout(dout_a),
    .full_cnt(fc_a), .wbank(wb_a), .rbank(rb_a), .err_underflow(err_a));

  fmap_pingpong_ctrl #(.DATA_W(DW), .ADDR_W(AW), .N_BANK(2), .RD_LAT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_b),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .rd_bank_valid(rbv_b), .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done),
    .rd_dvalid(dv_b), .rd_data(rdata_b), .bram_we(we_b), .bram_waddr(waddr_b),
    .bram_din(din_b), .bram_raddr(raddr_b), .bram_dout(dout_b),
    .full_cnt(fc_b), .wbank(wb_b), .rbank(rb_b), .err_underflow(err_b));

  fmap_pingpong_ctrl #(.DATA_W(DW), .ADDR_W(AW), .N_BANK(3), .RD_LAT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_c),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .rd_bank_valid(rbv_c), .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done),
    .rd_dvalid(dv_c), .rd_data(rdata_c), .bram_we(we_c), .bram_waddr(waddr_c),
    .bram_din(din_c), .bram_raddr(raddr_c), .bram_dout(dout_c),
    .full_cnt(fc_c), .wbank(wb_c), .rbank(rb_c), .err_underflow(err_c));

  // BRAM models: synchronous write on port A, RD_LAT-cycle registered read on port B.
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (we_a[b]) mem_a[b][waddr_a[b*AW +: AW]] <= din_a[b*DW +: DW];
      dout_a[b*DW +: DW] <= mem_a[b][raddr_a];
      if (we_b[b]) mem_b[b][waddr_b[b*AW +: AW]] <= din_b[b*DW +: DW];
      s1_b[b*DW +: DW]   <= mem_b[b][raddr_b];
    end
    dout_b <= s1_b;
    for (int b = 0; b < 3; b++) begin
      if (we_c[b]) mem_c[b][waddr_c[b*AW +: AW]] <= din_c[b*DW +: DW];
      dout_c[b*DW +: DW] <= mem_c[b][raddr_c];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_valid = 1'b0; wr_last = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_done = 1'b0; rd_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wr_tile(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_valid = 1'b1; wr_last = 1'b1; wr_addr = addr; wr_data = data;
    tick();
    idle();
  endtask

  initial begin
    // Reset state, observed before any clock edge
    idle();
    rst_n = 1'b0;
    #3;
    chk("rst_full_cnt", fc_a, 0);
    chk("rst_wr_ready", wr_ready_a, 1);
    chk("rst_rd_bank_valid", rbv_a, 0);
    chk("rst_bram_we", we_a, 0);
    chk("rst_wbank", wb_a, 0);
    chk("rst_rbank", rb_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_dvalid", dv_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic ping-pong: 4-beat tile into bank 0, read back addr 2, release
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(i); wr_data = 64'hA0 + 64'(i); wr_last = (i == 3);
      #1;
      if (i == 2) begin
        chk("p1_bram_we", we_a, 2'b01);
        chk("p1_waddr_bank1", waddr_a[2*AW-1:AW], 2);
        chk("p1_din_bank1", din_a[2*DW-1:DW], 64'hA2);
      end
      tick();
    end
    idle();
    chk("p1_full_cnt", fc_a, 1);
    chk("p1_wbank", wb_a, 1);
    chk("p1_rd_bank_valid", rbv_a, 1);
    chk("p1_wr_ready", wr_ready_a, 1);
    rd_req = 1'b1; rd_addr = 4'd2;
    #1;
    chk("p1_bram_raddr", raddr_a, 2);
    tick();
    idle();
    chk("p1_dvalid", dv_a, 1);
    chk("p1_rd_data", rdata_a, 64'hA2);
    tick();
    chk("p1_dvalid_drop", dv_a, 0);
    rd_done = 1'b1;
    tick();
    idle();
    chk("p1_rel_full_cnt", fc_a, 0);
    chk("p1_rel_rbank", rb_a, 1);
    chk("p1_rel_rbv", rbv_a, 0);

    // Fill to full and stall
    wr_tile(4'd0, 64'h11);
    wr_tile(4'd0, 64'h22);
    chk("p2_full_cnt", fc_a, 2);
    chk("p2_wr_ready", wr_ready_a, 0);
    chk("p2_wbank", wb_a, 1);
    wr_valid = 1'b1; wr_last = 1'b1; wr_addr = 4'd7; wr_data = 64'h99;
    #1;
    chk("p2_stall_we", we_a, 0);
    tick();
    idle();
    chk("p2_stall_full_cnt", fc_a, 2);
    chk("p2_stall_wbank", wb_a, 1);
    rd_done = 1'b1;
    tick();
    idle();
    chk("p2_rel_wr_ready", wr_ready_a, 1);
    chk("p2_rel_full_cnt", fc_a, 1);
    chk("p2_rel_rbank", rb_a, 0);

    // Simultaneous commit and release at full_cnt=1
    wr_valid = 1'b1; wr_last = 1'b1; rd_done = 1'b1;
    tick();
    idle();
    chk("p3_full_cnt", fc_a, 1);
    chk("p3_wbank", wb_a, 0);
    chk("p3_rbank", rb_a, 1);
    chk("p3_err", err_a, 0);

    // Release during an in-flight read, RD_LAT=2
    do_reset();
    wr_tile(4'd5, 64'h5555_0000);
    wr_tile(4'd5, 64'h5555_1111);
    chk("p4_full_cnt", fc_b, 2);
    chk("p4_wbank", wb_b, 0);
    chk("p4_wr_ready", wr_ready_b, 0);
    rd_req = 1'b1; rd_addr = 4'd5; rd_done = 1'b1;
    tick();
    idle();
    chk("p4_rbank", rb_b, 1);
    chk("p4_full_after_rel", fc_b, 1);
    chk("p4_dvalid_lat1", dv_b, 0);
    tick();
    chk("p4_dvalid_lat2", dv_b, 1);
    chk("p4_rd_data", rdata_b, 64'h5555_0000);
    tick();
    chk("p4_dvalid_drop", dv_b, 0);

    // Underflow via rd_done alone
    do_reset();
    rd_done = 1'b1;
    tick();
    idle();
    chk("p5_done_err", err_a, 1);
    chk("p5_done_full_cnt", fc_a, 0);
    chk("p5_done_rbank", rb_a, 0);

    // Underflow via rd_req, then three tiles on the 3-bank instance
    do_reset();
    chk("p5_err_cleared", err_c, 0);
    rd_req = 1'b1; rd_addr = 4'd1;
    tick();
    idle();
    chk("p5_req_err", err_c, 1);
    chk("p5_req_dvalid", dv_c, 0);
    chk("p5_req_full_cnt", fc_c, 0);
    wr_tile(4'd1, 64'hC0);
    chk("p5_wbank_t0", wb_c, 1);
    chk("p5_full_t0", fc_c, 1);
    wr_tile(4'd1, 64'hC1);
    chk("p5_wbank_t1", wb_c, 2);
    chk("p5_full_t1", fc_c, 2);
    wr_tile(4'd1, 64'hC2);
    chk("p5_wbank_t2", wb_c, 0);
    chk("p5_full_t2", fc_c, 3);
    chk("p5_wr_ready_full", wr_ready_c, 0);
    rd_done = 1'b1;
    tick();
    tick();
    idle();
    chk("p5_rbank_2", rb_c, 2);
    chk("p5_full_1", fc_c, 1);
    rd_req = 1'b1; rd_addr = 4'd1;
    tick();
    idle();
    chk("p5_dvalid", dv_c, 1);
    chk("p5_rd_data", rdata_c, 64'hC2);
    rd_done = 1'b1;
    tick();
    idle();
    chk("p5_rbank_wrap", rb_c, 0);
    chk("p5_full_0", fc_c, 0);
    chk("p5_err_sticky", err_c, 1);

    // Asynchronous reset between read acceptance and data return, RD_LAT=2
    do_reset();
    wr_tile(4'd3, 64'hD3);
    rd_req = 1'b1; rd_addr = 4'd3;
    tick();
    idle();
    chk("p6_dvalid_pre", dv_b, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("p6_async_full_cnt", fc_b, 0);
    chk("p6_async_wr_ready", wr_ready_b, 1);
    chk("p6_async_rbv", rbv_b, 0);
    tick();
    chk("p6_dvalid_in_rst", dv_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("p6_dvalid_after_rst", dv_b, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fmap_pingpong_ctrl.md
Name: fmap_pingpong_ctrl

Overview:
- Parametrised N-bank ping-pong controller for inter-layer feature-map BRAMs (e.g. conv2 array buffers, 64-bit wide, 4k deep).
- Owns bank-ownership state between a producer layer (PE writing an ofmap tile) and a consumer layer (next PE reading the ifmap tile).
- Generates per-bank BRAM write/read controls and muxes read data.
- Generalises the fixed two-bank scheme to N_BANK banks, configurable data/address width and BRAM read latency, with underflow/misuse flags.

Parameters:
- DATA_W, 64, bank word width in bits.
- ADDR_W, 12, bank address width; depth = 2**ADDR_W.
- N_BANK, 2, number of banks; legal values 2..4.
- RD_LAT, 1, BRAM read latency in cycles; legal values 1..2.

Ports:
- clk  in  1  sole clock; all BRAMs on the same clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  producer write beat valid.
- wr_ready  out  1  a free bank is available for writing.
- wr_addr  in  ADDR_W  word address within the current write bank.
- wr_data  in  DATA_W  write data.
- wr_last  in  1  qualifies the accepted beat as the final beat of the tile; commits the bank.
- rd_bank_valid  out  1  a committed (full) bank is available to the consumer.
- rd_req  in  1  consumer read request.
- rd_addr  in  ADDR_W  read address within the current read bank.
- rd_done  in  1  single-cycle pulse that releases the current read bank.
- rd_dvalid  out  1  rd_data valid, RD_LAT cycles after an accepted rd_req.
- rd_data  out  DATA_W  read data.
- bram_we  out  N_BANK  per-bank write enable (port A).
- bram_waddr  out  N_BANK*ADDR_W  per-bank write address (port A).
- bram_din  out  N_BANK*DATA_W  per-bank write data (port A).
- bram_raddr  out  ADDR_W  read address, broadcast to port B of all banks.
- bram_dout  in  N_BANK*DATA_W  per-bank read data (port B).
- full_cnt  out  3  number of committed, unreleased banks (0..N_BANK).
- wbank  out  2  current write bank index.
- rbank  out  2  current read bank index.
- err_underflow  out  1  sticky flag: rd_req or rd_done received while rd_bank_valid=0.

Behaviour:
- Reset (asynchronous, while rst_n=0): full_cnt=0, wbank=0, rbank=0, err_underflow=0, rd_dvalid pipeline cleared.
  - Resulting outputs: wr_ready=1, rd_bank_valid=0, bram_we=0.
  - Reset mid-operation logically discards all bank contents. In-flight reads return no rd_dvalid.
- Flow control: wr_ready = (full_cnt < N_BANK). rd_bank_valid = (full_cnt != 0). Both are combinational from registers only.
- Write path (combinational, zero added latency):
  - The write is accepted when wr_acc = wr_valid & wr_ready.
  - bram_we[wbank] = wr_acc; all other bits are 0.
  - Every bank's waddr/din slice = wr_addr/wr_data.
- Commit: wr_acc & wr_last → at the next edge, wbank = (wbank+1) mod N_BANK.
  - wr_last without wr_acc is ignored.
- Read path:
  - A read is accepted when rd_acc = rd_req & rd_bank_valid. bram_raddr = rd_addr.
  - rbank is captured into an RD_LAT-deep index pipeline alongside rd_acc.
  - rd_dvalid = rd_acc delayed RD_LAT cycles.
  - rd_data = slice of bram_dout selected by the delayed index. The data therefore stays correct if rd_done releases the bank while reads are in flight.
- Release: rd_done & rd_bank_valid → at the next edge, rbank = (rbank+1) mod N_BANK.
- full_cnt update per edge: +1 on commit, −1 on release. A commit and a release in the same cycle leave full_cnt unchanged, and both pointers advance.
- Underflow:
  - rd_req with rd_bank_valid=0 issues no read and sets err_underflow.
  - rd_done with rd_bank_valid=0 is ignored and sets err_underflow.
  - err_underflow clears only on reset.
- Full condition: at full_cnt=N_BANK, wr_ready=0. The producer stalls and no BRAM write occurs. Stalling is not an error.
- Pointer wrap: indices wrap modulo N_BANK, including non-power-of-two N_BANK=3.
- Widths: full_cnt and the index outputs are fixed at 3 and 2 bits; unused upper bits are 0.

Decomposition:
- Shared package fmap_buf_pkg holds:
  - bank-count limits (MAX_BANK=4);
  - index width constant (BANK_IDX_W=2);
  - count width constant (BANK_CNT_W=3).
- One natural sub-module: rd_lat_pipe, a parametrised RD_LAT-deep shift register carrying {valid, bank index}.
- Bank state is fully described by the two pointers plus full_cnt; no per-bank state machine is needed.

Test Plan:
- Basic ping-pong (N_BANK=2, RD_LAT=1):
  - Stimulus: write addr 0..3 with data 0xA0..0xA3, wr_last on addr 3.
  - Response: full_cnt=1, wbank=1, rd_bank_valid=1.
  - Then read addr 2 → rd_dvalid one cycle later with rd_data=0xA3? No: rd_data=0xA2 (data written at addr 2). rd_done → full_cnt=0, rbank=1.
- Fill to full:
  - Stimulus: commit 2 tiles with no release.
  - Response: wr_ready=0, and a further wr_valid produces bram_we=0.
  - Then rd_done → wr_ready=1 in the next cycle.
- Simultaneous commit and release at full_cnt=1:
  - Response: full_cnt stays 1; wbank and rbank both advance by 1.
- Release during in-flight read (RD_LAT=2):
  - Stimulus: read bank 0 addr 5, pulse rd_done in the same cycle, with bank 1 also full.
  - Response: the rd_data returned 2 cycles later is bank 0's word, not bank 1's.
- Underflow (N_BANK=3):
  - Stimulus: rd_req with full_cnt=0.
  - Response: no rd_dvalid, err_underflow=1. It stays 1 after 3 successful tiles; wbank wraps 0→1→2→0.
- Asynchronous reset mid-read:
  - Stimulus: drop rst_n between rd_acc and the data return.
  - Response: rd_dvalid never asserts; full_cnt=0, wr_ready=1 immediately, without waiting for a clock edge.
